// File: rtl/fm_factor_scheduler_if.sv
// Bus bundle between the FM factor scheduler, its sample source, coefficient ROM and divider.
interface fm_factor_scheduler_if;
  logic [7:0]  sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        sample_tick;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        period_done;
  logic [15:0] factor_out;
  logic        factor_load;
  logic [7:0]  underrun_cnt;
  logic        tick_miss;

  // Environment side: sample source, ROM and divider
  modport master (
    output sample_in, sample_valid, sample_tick, rom_data, period_done,
    input  sample_ready, rom_addr, factor_out, factor_load, underrun_cnt, tick_miss
  );

  // Scheduler side
  modport slave (
    input  sample_in, sample_valid, sample_tick, rom_data, period_done,
    output sample_ready, rom_addr, factor_out, factor_load, underrun_cnt, tick_miss
  );
endinterface

// File: rtl/fm_factor_scheduler.sv
// FM factor scheduler: buffers audio samples, looks each one up in the coefficient
// ROM on an audio tick and hands the result to the divider on a period boundary.
module fm_factor_scheduler #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [15:0] IDLE_FACTOR = 16'h031F,
  parameter logic [15:0] MIN_FACTOR  = 16'h0002
) (
  input logic                  clk,
  input logic                  reset,
  fm_factor_scheduler_if.slave bus
);
  localparam int unsigned PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W      = PTR_W + 1;
  localparam logic [7:0]  RESET_ADDR = 8'h80;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ARMED} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_tick_pending;
  logic              r_tick_miss;
  logic [7:0]        r_rom_addr;
  logic [7:0]        r_underrun;
  logic [15:0]       r_staged;
  logic [15:0]       r_factor_out;
  logic              r_factor_load;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_tick;
  logic w_pop;
  logic w_underrun;
  logic w_capture;
  logic w_apply;
  logic w_serve;

  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.sample_valid && !w_full;
  assign w_tick  = r_tick_pending || bus.sample_tick;
  assign w_serve = w_pop || w_underrun;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and per-cycle control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_underrun  = 1'b0;
    w_capture   = 1'b0;
    w_apply     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            w_underrun  = 1'b1;
          end
        end
      end
      S_FETCH: begin
        w_capture   = 1'b1;
        w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (bus.period_done) begin
          w_apply     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sample storage; contents are meaningless until the pointers say otherwise
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.sample_in;
  end

  // FIFO pointers and occupancy; a push while full never reaches here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Tick latch: one tick may queue; a second one while queued is counted as lost
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_pending <= 1'b0;
      r_tick_miss    <= 1'b0;
    end else if (w_serve) begin
      // A fresh strobe arriving alongside an already-queued tick stays queued
      r_tick_pending <= r_tick_pending && bus.sample_tick;
    end else if (bus.sample_tick) begin
      r_tick_pending <= 1'b1;
      if (r_tick_pending) r_tick_miss <= 1'b1;
    end
  end

  // ROM address, staged factor, divider factor and underrun counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rom_addr    <= RESET_ADDR;
      r_staged      <= IDLE_FACTOR;
      r_factor_out  <= IDLE_FACTOR;
      r_factor_load <= 1'b0;
      r_underrun    <= '0;
    end else begin
      r_factor_load <= w_apply;
      if (w_pop)     r_rom_addr <= r_mem[r_rd_ptr];
      if (w_capture) r_staged   <= (bus.rom_data < MIN_FACTOR) ? MIN_FACTOR : bus.rom_data;
      if (w_apply)   r_factor_out <= r_staged;
      if (w_underrun && (r_underrun != 8'hFF)) r_underrun <= r_underrun + 8'(1);
    end
  end

  assign bus.sample_ready = !w_full;
  assign bus.rom_addr     = r_rom_addr;
  assign bus.factor_out   = r_factor_out;
  assign bus.factor_load  = r_factor_load;
  assign bus.underrun_cnt = r_underrun;
  assign bus.tick_miss    = r_tick_miss;
endmodule

// File: tb/tb_fm_factor_scheduler.sv
// Directed bench for fm_factor_scheduler with a combinational coefficient ROM model.
module tb_fm_factor_scheduler;
  logic clk = 1'b0;
  logic reset;

  fm_factor_scheduler_if bus ();

  fm_factor_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [256];
  assign bus.rom_data = rom[bus.rom_addr];

  int checks = 0;
  int errors = 0;
  int load_pulses = 0;
  logic [15:0] cur_factor;

  // Count factor_load pulses mid-cycle
  always @(negedge clk) if (bus.factor_load === 1'b1) load_pulses++;

  typedef struct {
    logic [7:0]  sample;
    logic [15:0] rom_val;
    logic [15:0] exp_factor;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serve one queued sample: tick, fetch, wait in ARMED, apply on period_done
  task automatic serve(input logic [7:0] exp_addr, input logic [15:0] exp_fac,
                       input bit push_also, input logic [7:0] push_val);
    int lp0;
    lp0 = load_pulses;
    bus.sample_tick = 1'b1;
    if (push_also) begin
      bus.sample_valid = 1'b1;
      bus.sample_in    = push_val;
    end
    step();
    bus.sample_tick  = 1'b0;
    bus.sample_valid = 1'b0;
    check("rom_addr", 32'(bus.rom_addr), 32'(exp_addr));
    bus.period_done = 1'b1;
    step();
    bus.period_done = 1'b0;
    check("hold_in_fetch", 32'(bus.factor_out), 32'(cur_factor));
    repeat (10) step();
    check("hold_in_armed", 32'(bus.factor_out), 32'(cur_factor));
    bus.period_done = 1'b1;
    step();
    bus.period_done = 1'b0;
    check("factor_out", 32'(bus.factor_out), 32'(exp_fac));
    check("factor_load_hi", 32'(bus.factor_load), 32'd1);
    step();
    check("factor_load_lo", 32'(bus.factor_load), 32'd0);
    check("load_pulse_count", 32'(load_pulses - lp0), 32'd1);
    cur_factor = exp_fac;
  endtask

  task automatic push(input logic [7:0] s);
    bus.sample_valid = 1'b1;
    bus.sample_in    = s;
    step();
    bus.sample_valid = 1'b0;
  endtask

  task automatic empty_tick();
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    step();
  endtask

  task automatic check_reset_values();
    check("rst_factor_out", 32'(bus.factor_out), 32'h031F);
    check("rst_factor_load", 32'(bus.factor_load), 32'd0);
    check("rst_sample_ready", 32'(bus.sample_ready), 32'd1);
    check("rst_rom_addr", 32'(bus.rom_addr), 32'h80);
    check("rst_underrun", 32'(bus.underrun_cnt), 32'd0);
    check("rst_tick_miss", 32'(bus.tick_miss), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    int lp;
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      rom[i] = {b, b};
    end
    vecs[0] = '{8'h04, 16'h6407, 16'h6407};
    vecs[1] = '{8'h00, 16'h0000, 16'h0002};
    vecs[2] = '{8'h01, 16'h0001, 16'h0002};
    vecs[3] = '{8'h02, 16'h0002, 16'h0002};
    vecs[4] = '{8'h03, 16'h0003, 16'h0003};
    vecs[5] = '{8'h80, 16'h8000, 16'h8000};
    vecs[6] = '{8'hFF, 16'hFFFF, 16'hFFFF};
    for (int i = 0; i < 7; i++) rom[vecs[i].sample] = vecs[i].rom_val;

    reset            = 1'b1;
    bus.sample_in    = 8'h00;
    bus.sample_valid = 1'b0;
    bus.sample_tick  = 1'b0;
    bus.period_done  = 1'b0;
    cur_factor       = 16'h031F;

    // Reset state and quiet idle after release
    step();
    step();
    check_reset_values();
    reset = 1'b0;
    repeat (5) step();
    check("idle_factor_out", 32'(bus.factor_out), 32'h031F);
    check("idle_no_load", 32'(load_pulses), 32'd0);
    check("idle_ready", 32'(bus.sample_ready), 32'd1);

    // Table: one push + tick + period boundary per record
    for (int i = 0; i < 7; i++) begin
      push(vecs[i].sample);
      serve(vecs[i].sample, vecs[i].exp_factor, 1'b0, 8'h00);
    end

    // Extra ticks while ARMED: one queues, the next is lost
    push(8'h20);
    push(8'h21);
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    check("miss_rom_addr0", 32'(bus.rom_addr), 32'h20);
    step();
    bus.sample_tick = 1'b1;
    step();
    step();
    bus.sample_tick = 1'b0;
    check("tick_miss_set", 32'(bus.tick_miss), 32'd1);
    step();
    bus.period_done = 1'b1;
    step();
    bus.period_done = 1'b0;
    check("miss_factor0", 32'(bus.factor_out), 32'h2020);
    step();
    check("miss_rom_addr1", 32'(bus.rom_addr), 32'h21);
    cur_factor = 16'h2020;
    step();
    repeat (3) step();
    bus.period_done = 1'b1;
    step();
    bus.period_done = 1'b0;
    check("miss_factor1", 32'(bus.factor_out), 32'h2121);
    cur_factor = 16'h2121;
    repeat (6) step();
    check("miss_no_extra_serve", 32'(bus.rom_addr), 32'h21);
    check("miss_no_underrun", 32'(bus.underrun_cnt), 32'd0);

    // Fill the FIFO; fifth push and a push alongside a pop while full are dropped
    for (int i = 0; i < 5; i++) begin
      bus.sample_valid = 1'b1;
      bus.sample_in    = 8'(8'h10 + i);
      step();
      check("ready_during_fill", 32'(bus.sample_ready), (i < 3) ? 32'd1 : 32'd0);
    end
    bus.sample_valid = 1'b0;
    serve(8'h10, 16'h1010, 1'b1, 8'h55);
    check("ready_after_pop", 32'(bus.sample_ready), 32'd1);
    serve(8'h11, 16'h1111, 1'b0, 8'h00);
    serve(8'h12, 16'h1212, 1'b0, 8'h00);
    serve(8'h13, 16'h1313, 1'b0, 8'h00);

    // Empty-FIFO ticks count underruns and saturate
    lp = load_pulses;
    repeat (3) empty_tick();
    check("underrun_3", 32'(bus.underrun_cnt), 32'd3);
    check("underrun_factor_kept", 32'(bus.factor_out), 32'(cur_factor));
    check("underrun_rom_kept", 32'(bus.rom_addr), 32'h13);
    check("underrun_no_load", 32'(load_pulses - lp), 32'd0);
    repeat (252) empty_tick();
    check("underrun_255", 32'(bus.underrun_cnt), 32'hFF);
    repeat (4) empty_tick();
    check("underrun_saturated", 32'(bus.underrun_cnt), 32'hFF);

    // Reset while ARMED with a sample still buffered
    push(8'h30);
    push(8'h31);
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    step();
    step();
    lp = load_pulses;
    reset = 1'b1;
    #1;
    check_reset_values();
    step();
    reset = 1'b0;
    step();
    bus.period_done = 1'b1;
    step();
    bus.period_done = 1'b0;
    step();
    check("post_rst_factor", 32'(bus.factor_out), 32'h031F);
    check("post_rst_no_load", 32'(load_pulses - lp), 32'd0);
    empty_tick();
    check("post_rst_fifo_empty", 32'(bus.underrun_cnt), 32'd1);
    check("post_rst_rom_addr", 32'(bus.rom_addr), 32'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fm_factor_scheduler.md
FM_FACTOR_SCHEDULER -- requirements
Module: fm_factor_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: audio sample buffer entries, power of two.
REQ-002 Parameter IDLE_FACTOR, default 16'h031F: divider factor after reset (ROM entry for sample 8'h80, carrier centre).
REQ-003 Parameter MIN_FACTOR, default 16'h0002: lowest factor ever issued to the divider.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  single clock, same domain as the divider (500 MHz class).
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 sample_in  input  8  unsigned audio sample.
REQ-008 sample_valid  input  1  sample_in offered.
REQ-009 sample_ready  output  1  FIFO can accept; high = not full.
REQ-010 sample_tick  input  1  one-cycle audio-rate strobe (22050 Hz).
REQ-011 rom_addr  output  8  registered M-coefficient ROM address.
REQ-012 rom_data  input  16  ROM word, valid one cycle after rom_addr changes.
REQ-013 period_done  input  1  one-cycle pulse from the divider at each output-period boundary.
REQ-014 factor_out  output  16  factor driving the divider's in_factor.
REQ-015 factor_load  output  1  one-cycle pulse in the cycle factor_out changes.
REQ-016 underrun_cnt  output  8  ticks that found the FIFO empty, saturating.
REQ-017 tick_miss  output  1  sticky: a tick was lost while another was pending.

Function
REQ-018 Push: sample_valid && sample_ready at a rising edge SHALL write sample_in to the FIFO; a push while full SHALL be ignored, even if a pop happens in the same cycle.
REQ-019 Tick latch: sample_tick SHALL set tick_pending; a tick arriving while tick_pending is already set SHALL set tick_miss and not queue a second tick.
REQ-020 FSM states SHALL be IDLE, FETCH and ARMED.
REQ-021 IDLE with tick_pending (or sample_tick this cycle) and FIFO not empty: pop the head, register it onto rom_addr, clear tick_pending, go to FETCH.
REQ-022 IDLE with a tick and FIFO empty: increment underrun_cnt (saturate at 8'hFF), clear tick_pending, stay in IDLE, keep factor_out.
REQ-023 FETCH (one cycle): capture staged = max(rom_data, MIN_FACTOR), unsigned 16-bit compare, go to ARMED.
REQ-024 ARMED: hold until period_done; on it, factor_out <= staged, factor_load = 1 for exactly that cycle, go to IDLE.
REQ-025 period_done in IDLE or FETCH SHALL be ignored; factor_out SHALL change only on a period boundary, so the divider never sees a mid-period change.
REQ-026 Latency: pop to staged = 2 edges; application = first period_done sampled in ARMED.
REQ-027 Ticks arriving in FETCH or ARMED SHALL be latched per REQ-019 and served at the next IDLE cycle.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL range 0..FIFO_DEPTH; push and pop in the same cycle when not full SHALL keep occupancy unchanged.
REQ-029 Samples SHALL be consumed in order, one per served tick; no sample is skipped or repeated.

Reset
REQ-030 While reset is high: FSM = IDLE, FIFO empty, sample_ready = 1, rom_addr = 8'h80, factor_out = IDLE_FACTOR, staged = IDLE_FACTOR, factor_load = 0, tick_pending = 0, tick_miss = 0, underrun_cnt = 0.
REQ-031 Reset asserted mid-operation (FETCH or ARMED) SHALL abandon the staged factor and discard FIFO contents; no factor_load pulse SHALL occur during or as a result of reset.

Verification
REQ-032 Reset release, no stimulus -> factor_out = 16'h031F, factor_load never pulses, sample_ready = 1.
REQ-033 Push 8'h04, tick, ROM[04] = 16'h6407, period_done 10 cycles later -> rom_addr = 04 one edge after the tick; factor_out = 16'h6407 with a single factor_load in the period_done cycle.
REQ-034 Push 8'h00 with ROM[00] = 16'h0000, tick, period_done -> factor_out = 16'h0002 (MIN_FACTOR clamp).
REQ-035 Push 5 samples back-to-back with no ticks -> 4 accepted, sample_ready = 0 after the 4th; 5th ignored; four ticks then apply samples 1-4 in order.
REQ-036 Three ticks with FIFO empty -> underrun_cnt = 3, factor_out unchanged; 256 further empty ticks -> underrun_cnt = 8'hFF.
REQ-037 Tick, then two more ticks while ARMED waiting for period_done -> tick_miss = 1; exactly one extra sample served after ARMED exits.
